// File: rtl/mvm_pkg.sv
// Shared types and default geometry for the 8x8 matrix-vector MAC engine controller.
package mvm_pkg;

    localparam int DEF_ROWS       = 8;
    localparam int DEF_COLS       = 8;
    localparam int DEF_DATA_WIDTH = 8;

    typedef logic [DEF_COLS*DEF_DATA_WIDTH-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        UNPACK,
        CALC,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/word_unpacker.sv
// Holds one memory word and presents it byte-serially, byte 0 first; a stall holds the
// current byte in place so nothing is dropped while the target FIFO is full.
module word_unpacker #(
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_load,
    input  logic [COLS*DATA_WIDTH-1:0] i_word,
    input  logic                       i_advance,
    input  logic                       i_stall,
    output logic [DATA_WIDTH-1:0]      o_byte,
    output logic                       o_valid,
    output logic                       o_last
);

    localparam int IDX_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic [COLS*DATA_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_valid;
    logic                       w_step;

    assign w_step = r_valid && i_advance && !i_stall;

    // NOTE: registers are updated with <= so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (w_step) begin
            r_shift <= r_shift >> DATA_WIDTH;
            r_idx   <= r_idx + 1'b1;
            if (o_last) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_byte  = r_shift[DATA_WIDTH-1:0];
    assign o_valid = r_valid;
    assign o_last  = r_valid && (r_idx == IDX_W'(COLS - 1));

endmodule

// File: rtl/matvec_sequencer.sv
// Fill/compute controller for the matrix-vector MAC engine: reads B then the A rows from
// memory, scatters their bytes into the FIFOs, then runs the MAC chain until drained.
module matvec_sequencer
    import mvm_pkg::*;
#(
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = 32,
    parameter int BASE_ADDR    = 0,
    parameter int DRAIN_CYCLES = ROWS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH-1:0]      mem_address,
    output logic                       mem_read,
    input  logic [COLS*DATA_WIDTH-1:0] mem_readdata,
    input  logic                       mem_readdatavalid,
    input  logic                       mem_waitrequest,
    output logic [DATA_WIDTH-1:0]      fifo_wrdata,
    output logic [ROWS-1:0]            fifo_a_wrreq,
    output logic                       fifo_b_wrreq,
    input  logic [ROWS-1:0]            fifo_a_wrfull,
    input  logic                       fifo_b_wrfull,
    input  logic [ROWS-1:0]            fifo_a_rdempty,
    input  logic                       fifo_b_rdempty,
    output logic                       mac_clr,
    output logic                       mac_en
);

    localparam int WORD_W  = $clog2(ROWS + 2);
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_e                r_state;
    logic [WORD_W-1:0]     r_word;
    logic [DRAIN_W-1:0]    r_drain;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic                  r_mem_read;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_mac_clr;
    logic                  r_mac_en;

    logic [ROW_W-1:0]      w_row;
    logic                  w_target_full;
    logic                  w_emit;
    logic                  w_load;
    logic                  w_all_empty;
    logic [DATA_WIDTH-1:0] w_byte;
    logic                  w_valid;
    logic                  w_last;

    // Word 0 is B; word r+1 is A row r, so the row index is simply word-1.
    assign w_row         = ROW_W'(r_word - 1'b1);
    assign w_target_full = (r_word == '0) ? fifo_b_wrfull : fifo_a_wrfull[w_row];
    assign w_emit        = (r_state == UNPACK) && w_valid && !w_target_full;
    assign w_load        = (r_state == WAIT) && mem_readdatavalid;
    assign w_all_empty   = (&fifo_a_rdempty) && fifo_b_rdempty;

    word_unpacker #(
        .COLS       (COLS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_unpacker (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_word    (mem_readdata),
        .i_advance (r_state == UNPACK),
        .i_stall   (w_target_full),
        .o_byte    (w_byte),
        .o_valid   (w_valid),
        .o_last    (w_last)
    );

    // NOTE: defaulting every always_comb output before the conditional keeps it free of latches.
    always_comb begin
        fifo_a_wrreq = '0;
        fifo_b_wrreq = 1'b0;
        if (w_emit) begin
            if (r_word == '0) begin
                fifo_b_wrreq = 1'b1;
            end else begin
                fifo_a_wrreq[w_row] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_word        <= '0;
            r_drain       <= '0;
            r_mem_address <= '0;
            r_mem_read    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mac_clr     <= 1'b0;
            r_mac_en      <= 1'b0;
        end else begin
            r_mac_clr <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_mac_clr     <= 1'b1;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_word        <= '0;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= BASE;
                        r_state       <= REQ;
                    end
                end
                REQ: begin
                    if (!mem_waitrequest) begin
                        r_mem_read <= 1'b0;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_readdatavalid) begin
                        r_state <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (w_emit && w_last) begin
                        r_word <= r_word + 1'b1;
                        if (r_word == WORD_W'(ROWS)) begin
                            r_mac_en <= 1'b1;
                            r_state  <= CALC;
                        end else begin
                            r_mem_read    <= 1'b1;
                            r_mem_address <= BASE + ADDR_WIDTH'(r_word) + ADDR_WIDTH'(1);
                            r_state       <= REQ;
                        end
                    end
                end
                CALC: begin
                    if (w_all_empty) begin
                        r_drain <= DRAIN_W'(DRAIN_CYCLES - 1);
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Keeps the chain enabled long enough for the systolic skew to flush out.
                    if (r_drain == '0) begin
                        r_mac_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign mem_address = r_mem_address;
    assign mem_read    = r_mem_read;
    assign fifo_wrdata = w_byte;
    assign mac_clr     = r_mac_clr;
    assign mac_en      = r_mac_en;

endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench for matvec_sequencer: a 1-cycle-latency memory model, FIFO occupancy
// models, and per-run checks of read order, FIFO contents and start-to-done latency.
module tb_matvec_sequencer;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int W    = COLS * DW;
    localparam int NF   = ROWS + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            busy, done, mem_read, mac_clr, mac_en, fifo_b_wrreq;
    logic [AW-1:0]   mem_address;
    logic [W-1:0]    mem_readdata = '0;
    logic            mem_readdatavalid = 1'b0;
    logic            mem_waitrequest = 1'b0;
    logic [DW-1:0]   fifo_wrdata;
    logic [ROWS-1:0] fifo_a_wrreq;
    logic [ROWS-1:0] fifo_a_wrfull = '0;
    logic            fifo_b_wrfull = 1'b0;
    logic [ROWS-1:0] fifo_a_rdempty = '1;
    logic            fifo_b_rdempty = 1'b1;

    always #5 clk = ~clk;

    matvec_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_waitrequest   (mem_waitrequest),
        .fifo_wrdata       (fifo_wrdata),
        .fifo_a_wrreq      (fifo_a_wrreq),
        .fifo_b_wrreq      (fifo_b_wrreq),
        .fifo_a_wrfull     (fifo_a_wrfull),
        .fifo_b_wrfull     (fifo_b_wrfull),
        .fifo_a_rdempty    (fifo_a_rdempty),
        .fifo_b_rdempty    (fifo_b_rdempty),
        .mac_clr           (mac_clr),
        .mac_en            (mac_en)
    );

    typedef struct {
        string name;
        int    stall_addr;
        int    stall_cyc;
        int    full_cyc;
        bit    inject;
        int    exp_cycles;
    } vec_t;

    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] reads[$];
    logic [DW-1:0] wlog[NF][$];
    int            occ[NF];
    bit            pend, full_arm, inject_arm, prev_wait, start_now, rst_now;
    logic [W-1:0]  pend_data;
    logic [AW-1:0] prev_addr;
    int            stall_addr, stall_left, full_left, full_cyc;
    int            viol, hold_bad, clr_cnt;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // FIFO f=0 is B (memory word 0 = bytes 1..8); f=r+1 is A row r (bytes 16*r + k).
    function automatic logic [DW-1:0] exp_byte(input int f, input int k);
        return (f == 0) ? DW'(k + 1) : DW'((f - 1) * 16 + k);
    endfunction

    function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
        logic [W-1:0] w;
        for (int k = 0; k < COLS; k++) w[k*DW +: DW] = exp_byte(int'(a), k);
        return w;
    endfunction

    task automatic clear_model();
        reads.delete();
        for (int f = 0; f < NF; f++) begin
            wlog[f].delete();
            occ[f] = 0;
        end
        pend = 0; full_arm = 0; inject_arm = 0; prev_wait = 0;
        stall_left = 0; full_left = 0; viol = 0; hold_bad = 0; clr_cnt = 0;
    endtask

    // One clock: drive inputs at the falling edge, then sample settled outputs 1 ns later.
    task automatic cycle();
        bit inj;
        @(negedge clk);
        inj = inject_arm && mac_en;
        if (inj) inject_arm = 0;
        rst_n             = rst_now;
        start             = start_now | inj;
        mem_readdatavalid = pend | inj;
        mem_readdata      = pend ? pend_data : {W{1'b1}};
        pend              = 0;
        if (full_arm && wlog[4].size() == 3) begin
            full_left = full_cyc;
            full_arm  = 0;
        end
        fifo_a_wrfull = (full_left > 0) ? 8'h08 : 8'h00;
        if (full_left > 0) full_left--;
        fifo_b_rdempty = (occ[0] == 0);
        for (int r = 0; r < ROWS; r++) fifo_a_rdempty[r] = (occ[r+1] == 0);
        mem_waitrequest = 1'b0;
        if (mem_read && mem_address == AW'(stall_addr) && stall_left > 0) begin
            mem_waitrequest = 1'b1;
            stall_left--;
        end
        #1;
        if (prev_wait && !(mem_read && mem_address == prev_addr)) hold_bad++;
        prev_wait = mem_read && mem_waitrequest;
        prev_addr = mem_address;
        if (mem_read && !mem_waitrequest) begin
            reads.push_back(mem_address);
            pend      = 1;
            pend_data = mem_word(mem_address);
        end
        if (mac_clr) clr_cnt++;
        if ((fifo_a_wrreq & fifo_a_wrfull) != '0 || (fifo_b_wrreq && fifo_b_wrfull)) viol++;
        if (mac_en && (fifo_b_wrreq || fifo_a_wrreq != '0)) viol++;
        if ($countones({fifo_a_wrreq, fifo_b_wrreq}) > 1) viol++;
        if (fifo_b_wrreq) begin
            wlog[0].push_back(fifo_wrdata);
            occ[0]++;
        end
        for (int r = 0; r < ROWS; r++) begin
            if (fifo_a_wrreq[r]) begin
                wlog[r+1].push_back(fifo_wrdata);
                occ[r+1]++;
            end
        end
        if (mac_en) begin
            for (int f = 0; f < NF; f++) if (occ[f] > 0) occ[f]--;
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({busy, done, mem_read, mac_clr, mac_en, fifo_b_wrreq,
                    fifo_a_wrreq, mem_address, fifo_wrdata});
    endfunction

    task automatic run(input vec_t v);
        int n;
        bit ok;
        clear_model();
        stall_addr = v.stall_addr;
        stall_left = v.stall_cyc;
        full_cyc   = v.full_cyc;
        full_arm   = (v.full_cyc > 0);
        start_now  = 1;
        cycle();
        start_now  = 0;
        inject_arm = v.inject;
        cycle();
        check({v.name, " clr/busy/done/read after start"}, 64'({mac_clr, busy, done, mem_read}), 64'(4'b1101));
        check({v.name, " first address"}, 64'(mem_address), 64'(0));
        n = 1;
        while (!done && n < 1000) begin
            cycle();
            n++;
        end
        check({v.name, " cycles start to done"}, 64'(n), 64'(v.exp_cycles));
        check({v.name, " busy/mac_en/done at end"}, 64'({busy, mac_en, done}), 64'(3'b001));
        check({v.name, " read count"}, 64'(reads.size()), 64'(NF));
        ok = (reads.size() == NF);
        for (int i = 0; i < reads.size() && i < NF; i++) ok &= (reads[i] == AW'(i));
        check({v.name, " read order"}, 64'(ok), 64'(1));
        for (int f = 0; f < NF; f++) begin
            ok = (wlog[f].size() == COLS);
            for (int k = 0; k < wlog[f].size() && k < COLS; k++) ok &= (wlog[f][k] == exp_byte(f, k));
            check($sformatf("%s fifo%0d contents", v.name, f), 64'(ok), 64'(1));
        end
        check({v.name, " strobe violations"}, 64'(viol), 64'(0));
        check({v.name, " request held under waitrequest"}, 64'(hold_bad), 64'(0));
        check({v.name, " mac_clr pulses"}, 64'(clr_cnt), 64'(1));
        if (v.inject) check({v.name, " injection applied"}, 64'(inject_arm), 64'(0));
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        bit seen;
        vecs[0] = '{"plain",    -1, 0, 0, 1'b0, 108};
        vecs[1] = '{"waitreq",   2, 3, 0, 1'b0, 111};
        vecs[2] = '{"wrfull",   -1, 0, 5, 1'b0, 113};
        vecs[3] = '{"inject",   -1, 0, 0, 1'b1, 108};
        vecs[4] = '{"combined",  5, 2, 5, 1'b1, 115};

        clear_model();
        stall_addr = -1;
        rst_now    = 0;
        start_now  = 0;
        repeat (3) cycle();
        check("outputs in reset", all_outputs(), 64'(0));
        start_now = 1;
        cycle();
        start_now = 0;
        rst_now   = 1;
        cycle();
        cycle();
        check("start during reset ignored", all_outputs(), 64'(0));

        for (int i = 0; i < 5; i++) run(vecs[i]);

        repeat (3) cycle();
        check("done held in DONE", 64'({done, busy}), 64'(2'b10));
        run(vecs[0]);

        // Abort in the middle of unpacking word 4 (A row 3), then restart from scratch.
        clear_model();
        stall_addr = -1;
        start_now  = 1;
        cycle();
        start_now  = 0;
        seen = 0;
        n = 0;
        while (!seen && n < 300) begin
            cycle();
            seen = fifo_a_wrreq[3];
            n++;
        end
        check("reached row 3 unpack", 64'(seen), 64'(1));
        rst_now = 0;
        cycle();
        check("outputs after mid-run reset", all_outputs(), 64'(0));
        cycle();
        check("outputs held in reset", all_outputs(), 64'(0));
        rst_now = 1;
        cycle();
        check("idle after reset release", 64'({busy, done, mem_read}), 64'(0));
        run(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
